alu_execute_unit: RTL and testbench

Execute stage that consumes the decoded ALU operation (opcode, two signed operands, write-back flag and register code) and produces a register write-back. Single-cycle ops finish in one clock. MULT, DIV and REM run on a shared iterative shift datapath. The result is held on a valid/ready write-back port until the register file accepts it.

---
 rtl/alu_pkg.sv | 39 +++
 rtl/alu_iter_muldiv.sv | 107 ++++++++++
 rtl/alu_execute_unit.sv | 159 +++++++++++++++
 tb/tb_alu_execute_unit.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state type and iteration count for the ALU execute stage.
package alu_pkg;

    localparam int unsigned OP_W     = 5;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ITER_CNT = DATA_W;

    localparam logic [OP_W-1:0] OP_ADD  = 5'd1;
    localparam logic [OP_W-1:0] OP_SUB  = 5'd2;
    localparam logic [OP_W-1:0] OP_MULT = 5'd3;
    localparam logic [OP_W-1:0] OP_DIV  = 5'd4;
    localparam logic [OP_W-1:0] OP_REM  = 5'd5;
    localparam logic [OP_W-1:0] OP_ABS  = 5'd6;
    localparam logic [OP_W-1:0] OP_NOT  = 5'd7;
    localparam logic [OP_W-1:0] OP_AND  = 5'd8;
    localparam logic [OP_W-1:0] OP_NAND = 5'd9;
    localparam logic [OP_W-1:0] OP_OR   = 5'd10;
    localparam logic [OP_W-1:0] OP_NOR  = 5'd11;
    localparam logic [OP_W-1:0] OP_XOR  = 5'd12;
    localparam logic [OP_W-1:0] OP_XNOR = 5'd13;
    localparam logic [OP_W-1:0] OP_SET  = 5'd16;
    localparam logic [OP_W-1:0] OP_SLT  = 5'd17;
    localparam logic [OP_W-1:0] OP_SGT  = 5'd18;
    localparam logic [OP_W-1:0] OP_SDT  = 5'd19;
    localparam logic [OP_W-1:0] OP_SLET = 5'd21;
    localparam logic [OP_W-1:0] OP_SGET = 5'd22;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic is_muldiv(input logic [OP_W-1:0] op);
        return (op == OP_MULT) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Shared iterative datapath: shift-add multiply and restoring divide on magnitudes,
// with sign fix-up and divide-by-zero override applied on the held result.
module alu_iter_muldiv
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ITER_CNT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             step,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] v1,
    input  logic [WIDTH-1:0] v2,
    output logic             last_c,
    output logic [WIDTH-1:0] result_c,
    output logic             dbz_c
);

    localparam int unsigned CNT_W = 6;

    logic [WIDTH-1:0] acc_q, a_q, b_q, v1_q;
    logic [CNT_W-1:0] cnt_q;
    logic             div_q, rem_q, neg_q_q, neg_r_q, dbz_q;

    logic             mode_div;
    logic [WIDTH-1:0] src_acc, src_a, src_b;
    logic [WIDTH-1:0] acc_n, a_n, b_n;
    logic [WIDTH:0]   rem_sh, diff;
    logic [WIDTH-1:0] q_fix, r_fix;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? -x : x;
    endfunction

    // One datapath step; on start it runs on the fresh operands so the load edge is step 0
    always_comb begin
        mode_div = start ? (op != OP_MULT) : div_q;
        src_acc  = start ? '0 : acc_q;
        src_a    = start ? (mode_div ? mag(v2) : v1) : a_q;
        src_b    = start ? (mode_div ? mag(v1) : v2) : b_q;
        rem_sh   = {src_acc, src_b[WIDTH-1]};
        diff     = rem_sh - {1'b0, src_a};
        acc_n    = src_acc;
        a_n      = src_a;
        b_n      = src_b;
        if (mode_div) begin
            if (rem_sh >= {1'b0, src_a}) begin
                acc_n = diff[WIDTH-1:0];
                b_n   = {src_b[WIDTH-2:0], 1'b1};
            end else begin
                acc_n = rem_sh[WIDTH-1:0];
                b_n   = {src_b[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_n = src_acc + (src_b[0] ? src_a : '0);
            a_n   = {src_a[WIDTH-2:0], 1'b0};
            b_n   = {1'b0, src_b[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            v1_q    <= '0;
            cnt_q   <= '0;
            div_q   <= 1'b0;
            rem_q   <= 1'b0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            if (start || step) begin
                acc_q <= acc_n;
                a_q   <= a_n;
                b_q   <= b_n;
            end
            if (start) begin
                cnt_q   <= '0;
                v1_q    <= v1;
                div_q   <= (op != OP_MULT);
                rem_q   <= (op == OP_REM);
                neg_q_q <= v1[WIDTH-1] ^ v2[WIDTH-1];
                neg_r_q <= v1[WIDTH-1];
                dbz_q   <= (v2 == '0);
            end else if (step) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // Step 0 happened on the load edge, so the final step is at count WIDTH-2
    always_comb begin
        last_c = (cnt_q == CNT_W'(WIDTH - 2));
        q_fix  = neg_q_q ? -b_q : b_q;
        r_fix  = neg_r_q ? -acc_q : acc_q;
        if (dbz_q) begin
            q_fix = '1;
            r_fix = v1_q;
        end
        result_c = div_q ? (rem_q ? r_fix : q_fix) : acc_n;
        dbz_c    = div_q && dbz_q;
    end

endmodule

// File: rtl/alu_execute_unit.sv
// ALU execute stage: single-cycle ops computed combinationally, MULT/DIV/REM on the
// iterative datapath, result held on a valid/ready write-back port.
module alu_execute_unit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned REG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  ALU_op,
    input  logic [WIDTH-1:0] ALU_v1,
    input  logic [WIDTH-1:0] ALU_v2,
    input  logic             ALU_write_back_flag,
    input  logic [REG_W-1:0] ALU_write_back_code,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [REG_W-1:0] wb_reg,
    output logic [WIDTH-1:0] wb_data,
    output logic             div_by_zero,
    output logic             busy
);

    state_t           state;
    logic             flag_q;
    logic [REG_W-1:0] code_q;
    logic             md_div_q;

    logic             accept_c;
    logic             md_start_c;
    logic             op_ok_c;
    logic [WIDTH-1:0] single_c;
    logic             md_last_c;
    logic [WIDTH-1:0] md_result_c;
    logic             md_dbz_c;

    assign accept_c   = in_valid && in_ready && (state == IDLE);
    assign md_start_c = accept_c && is_muldiv(ALU_op);

    // Single-cycle results straight from the decoded operands
    always_comb begin
        single_c = '0;
        op_ok_c  = 1'b1;
        case (ALU_op)
            OP_ADD:  single_c = ALU_v1 + ALU_v2;
            OP_SUB:  single_c = ALU_v1 - ALU_v2;
            OP_ABS:  single_c = ALU_v1[WIDTH-1] ? -ALU_v1 : ALU_v1;
            OP_NOT:  single_c = ~ALU_v1;
            OP_AND:  single_c = ALU_v1 & ALU_v2;
            OP_NAND: single_c = ~(ALU_v1 & ALU_v2);
            OP_OR:   single_c = ALU_v1 | ALU_v2;
            OP_NOR:  single_c = ~(ALU_v1 | ALU_v2);
            OP_XOR:  single_c = ALU_v1 ^ ALU_v2;
            OP_XNOR: single_c = ~(ALU_v1 ^ ALU_v2);
            OP_SET:  single_c = ALU_v2;
            OP_SLT:  single_c = WIDTH'($signed(ALU_v1) <  $signed(ALU_v2));
            OP_SGT:  single_c = WIDTH'($signed(ALU_v1) >  $signed(ALU_v2));
            OP_SDT:  single_c = WIDTH'(ALU_v1 != ALU_v2);
            OP_SLET: single_c = WIDTH'($signed(ALU_v1) <= $signed(ALU_v2));
            OP_SGET: single_c = WIDTH'($signed(ALU_v1) >= $signed(ALU_v2));
            default: op_ok_c  = 1'b0;
        endcase
    end

    alu_iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk      (clk),
        .rst      (rst),
        .start    (md_start_c),
        .step     (state == ITER),
        .op       (ALU_op),
        .v1       (ALU_v1),
        .v2       (ALU_v2),
        .last_c   (md_last_c),
        .result_c (md_result_c),
        .dbz_c    (md_dbz_c)
    );

    // Control FSM with registered handshake and write-back outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            in_ready    <= 1'b1;
            busy        <= 1'b0;
            wb_valid    <= 1'b0;
            wb_reg      <= '0;
            wb_data     <= '0;
            div_by_zero <= 1'b0;
            flag_q      <= 1'b0;
            code_q      <= '0;
            md_div_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        flag_q   <= ALU_write_back_flag;
                        code_q   <= ALU_write_back_code;
                        md_div_q <= (ALU_op != OP_MULT);
                        if (is_muldiv(ALU_op)) begin
                            state    <= ITER;
                            in_ready <= 1'b0;
                            busy     <= 1'b1;
                        end else if (op_ok_c && ALU_write_back_flag) begin
                            state       <= DONE;
                            in_ready    <= 1'b0;
                            busy        <= 1'b1;
                            wb_valid    <= 1'b1;
                            wb_reg      <= ALU_write_back_code;
                            wb_data     <= single_c;
                            div_by_zero <= 1'b0;
                        end
                    end
                end
                ITER: begin
                    if (md_last_c) begin
                        if (md_div_q) begin
                            state <= FIX;
                        end else if (flag_q) begin
                            state       <= DONE;
                            wb_valid    <= 1'b1;
                            wb_reg      <= code_q;
                            wb_data     <= md_result_c;
                            div_by_zero <= 1'b0;
                        end else begin
                            state    <= IDLE;
                            in_ready <= 1'b1;
                            busy     <= 1'b0;
                        end
                    end
                end
                FIX: begin
                    if (flag_q) begin
                        state       <= DONE;
                        wb_valid    <= 1'b1;
                        wb_reg      <= code_q;
                        wb_data     <= md_result_c;
                        div_by_zero <= md_dbz_c;
                    end else begin
                        state    <= IDLE;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                    end
                end
                DONE: begin
                    if (wb_ready || !flag_q) begin
                        state       <= IDLE;
                        in_ready    <= 1'b1;
                        busy        <= 1'b0;
                        wb_valid    <= 1'b0;
                        div_by_zero <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_execute_unit.sv
// Directed self-checking bench for alu_execute_unit.
module tb_alu_execute_unit;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  ALU_op;
    logic [31:0] ALU_v1;
    logic [31:0] ALU_v2;
    logic        ALU_write_back_flag;
    logic [7:0]  ALU_write_back_code;
    logic        wb_valid;
    logic        wb_ready;
    logic [7:0]  wb_reg;
    logic [31:0] wb_data;
    logic        div_by_zero;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int hs_count = 0;

    alu_execute_unit #(.WIDTH(32), .REG_W(8)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .in_valid            (in_valid),
        .in_ready            (in_ready),
        .ALU_op              (ALU_op),
        .ALU_v1              (ALU_v1),
        .ALU_v2              (ALU_v2),
        .ALU_write_back_flag (ALU_write_back_flag),
        .ALU_write_back_code (ALU_write_back_code),
        .wb_valid            (wb_valid),
        .wb_ready            (wb_ready),
        .wb_reg              (wb_reg),
        .wb_data             (wb_data),
        .div_by_zero         (div_by_zero),
        .busy                (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (!rst && wb_valid && wb_ready) hs_count++;

    // Issue one op at a negedge, then look for the first wb_valid within the bound
    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic flag, input logic [7:0] code, input int bound,
                          output logic seen, output int lat, output logic [31:0] data,
                          output logic [7:0] rg, output logic dz);
        @(negedge clk);
        ALU_op = op; ALU_v1 = a; ALU_v2 = b;
        ALU_write_back_flag = flag; ALU_write_back_code = code;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        seen = 1'b0; lat = 0; data = '0; rg = '0; dz = 1'b0;
        for (int i = 1; i <= bound && !seen; i++) begin
            @(negedge clk);
            if (wb_valid) begin
                seen = 1'b1; lat = i; data = wb_data; rg = wb_reg; dz = div_by_zero;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({in_ready, wb_valid, busy, div_by_zero} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_flags: got {in_ready,wb_valid,busy,dbz}=%b expected 1000",
                     {in_ready, wb_valid, busy, div_by_zero});
        end
        checks++;
        if ({wb_reg, wb_data} !== 40'd0) begin
            errors++;
            $display("FAIL reset_data: got reg=%h data=%h expected 0/0", wb_reg, wb_data);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_add_throughput();
        logic seen; int lat; logic [31:0] d; logic [7:0] rg; logic dz;
        wb_ready = 1'b1;
        run_op(5'd1, 32'd7, 32'hFFFF_FFFD, 1'b1, 8'd5, 5, seen, lat, d, rg, dz);
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL add_latency: got %0d expected 1", lat); end
        checks++;
        if ({rg, d} !== {8'd5, 32'd4}) begin
            errors++; $display("FAIL add_result: got reg=%0d data=%h expected 5/00000004", rg, d);
        end
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL add_busy: got in_ready=%b busy=%b expected 0/1", in_ready, busy);
        end
        // handshake at the next edge; unit ready again one cycle later
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || wb_valid !== 1'b0) begin
            errors++; $display("FAIL add_ready_again: got in_ready=%b wb_valid=%b expected 1/0", in_ready, wb_valid);
        end
        ALU_op = 5'd2; ALU_v1 = 32'd10; ALU_v2 = 32'd3; ALU_write_back_code = 8'd6;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({wb_valid, wb_reg, wb_data} !== {1'b1, 8'd6, 32'd7}) begin
            errors++; $display("FAIL b2b_sub: got v=%b reg=%0d data=%h expected 1/6/00000007", wb_valid, wb_reg, wb_data);
        end
        @(negedge clk);
    endtask

    task automatic test_muldiv();
        logic [4:0]  op [9]  = '{5'd4, 5'd5, 5'd4, 5'd4, 5'd5, 5'd3, 5'd3, 5'd5, 5'd4};
        logic [31:0] a  [9]  = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd5, 32'h8000_0000, 32'h8000_0000,
                                 32'h0001_0000, 32'hFFFF_FFFD, 32'd7, 32'd7};
        logic [31:0] b  [9]  = '{32'd2, 32'd2, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                 32'h0001_0000, 32'd4, 32'd0, 32'hFFFF_FFFE};
        logic [31:0] ex [9]  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,
                                 32'd0, 32'hFFFF_FFF4, 32'd7, 32'hFFFF_FFFD};
        logic        ez [9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        int          el [9]  = '{33, 33, 33, 33, 33, 32, 32, 33, 33};
        logic seen; int lat; logic [31:0] d; logic [7:0] rg; logic dz;
        wb_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            run_op(op[i], a[i], b[i], 1'b1, 8'(20 + i), 50, seen, lat, d, rg, dz);
            checks++;
            if (lat !== el[i]) begin
                errors++; $display("FAIL muldiv_latency[%0d]: got %0d expected %0d", i, lat, el[i]);
            end
            checks++;
            if ({rg, d, dz} !== {8'(20 + i), ex[i], ez[i]}) begin
                errors++;
                $display("FAIL muldiv_result[%0d]: got reg=%0d data=%h dbz=%b expected %0d/%h/%b",
                         i, rg, d, dz, 20 + i, ex[i], ez[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_single();
        logic [4:0]  op [12] = '{5'd17, 5'd22, 5'd19, 5'd16, 5'd6, 5'd18, 5'd21, 5'd11,
                                 5'd13, 5'd9, 5'd2, 5'd1};
        logic [31:0] a  [12] = '{32'hFFFF_FFFF, 32'd3, 32'd3, 32'd9, 32'h8000_0000, 32'd5, 32'd4,
                                 32'hF0F0_F0F0, 32'h1234_5678, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        logic [31:0] b  [12] = '{32'd1, 32'd3, 32'd3, 32'd42, 32'd0, 32'hFFFF_FFFB, 32'd3,
                                 32'h0F0F_0000, 32'hFFFF_FFFF, 32'h0000_FFFF, 32'd1, 32'd1};
        logic [31:0] ex [12] = '{32'd1, 32'd1, 32'd0, 32'd42, 32'h8000_0000, 32'd1, 32'd0,
                                 32'h0000_0F0F, 32'h1234_5678, 32'hFFFF_0000, 32'h7FFF_FFFF, 32'h8000_0000};
        logic seen; int lat; logic [31:0] d; logic [7:0] rg; logic dz;
        wb_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            run_op(op[i], a[i], b[i], 1'b1, 8'(40 + i), 5, seen, lat, d, rg, dz);
            checks++;
            if ({lat == 1, rg, d, dz} !== {1'b1, 8'(40 + i), ex[i], 1'b0}) begin
                errors++;
                $display("FAIL single[%0d] op=%0d: got lat=%0d reg=%0d data=%h dbz=%b expected 1/%0d/%h/0",
                         i, op[i], lat, rg, d, dz, 40 + i, ex[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic seen; int lat; logic [31:0] d; logic [7:0] rg; logic dz;
        int hs0;
        wb_ready = 1'b0;
        hs0 = hs_count;
        run_op(5'd1, 32'd1, 32'd2, 1'b1, 8'd9, 5, seen, lat, d, rg, dz);
        checks++;
        if ({seen, rg, d} !== {1'b1, 8'd9, 32'd3}) begin
            errors++; $display("FAIL bp_first: got seen=%b reg=%0d data=%h expected 1/9/00000003", seen, rg, d);
        end
        for (int i = 0; i < 5; i++) begin
            ALU_op = 5'd12; ALU_v1 = 32'hAAAA_AAAA; ALU_v2 = 32'h5555_5555;
            ALU_write_back_code = 8'd77; in_valid = 1'b1;
            @(negedge clk);
            checks++;
            if ({wb_valid, in_ready, div_by_zero, wb_reg, wb_data} !== {3'b100, 8'd9, 32'd3}) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got v=%b rdy=%b dbz=%b reg=%0d data=%h expected 1/0/0/9/00000003",
                         i, wb_valid, in_ready, div_by_zero, wb_reg, wb_data);
            end
        end
        in_valid = 1'b0;
        wb_ready = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if ({wb_valid, in_ready} !== 2'b01 || hs_count - hs0 !== 1) begin
            errors++;
            $display("FAIL bp_once: got v=%b rdy=%b handshakes=%0d expected 0/1/1",
                     wb_valid, in_ready, hs_count - hs0);
        end
    endtask

    task automatic test_reset_mid_op();
        int seen_wb;
        wb_ready = 1'b1;
        @(negedge clk);
        ALU_op = 5'd4; ALU_v1 = 32'd100; ALU_v2 = 32'd7;
        ALU_write_back_flag = 1'b1; ALU_write_back_code = 8'd3; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({in_ready, busy, wb_valid} !== 3'b100) begin
            errors++; $display("FAIL rst_mid_state: got rdy=%b busy=%b v=%b expected 1/0/0", in_ready, busy, wb_valid);
        end
        seen_wb = 0;
        repeat (40) begin
            @(negedge clk);
            if (wb_valid) seen_wb++;
        end
        checks++;
        if (seen_wb !== 0) begin
            errors++; $display("FAIL rst_mid_no_wb: got %0d wb_valid cycles expected 0", seen_wb);
        end
    endtask

    task automatic test_drops();
        logic seen; int lat; logic [31:0] d; logic [7:0] rg; logic dz;
        wb_ready = 1'b1;
        run_op(5'd14, 32'd1, 32'd1, 1'b1, 8'd1, 40, seen, lat, d, rg, dz);
        checks++;
        if (seen !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL drop_op14: got seen=%b rdy=%b expected 0/1", seen, in_ready);
        end
        run_op(5'd1, 32'd1, 32'd1, 1'b0, 8'd2, 40, seen, lat, d, rg, dz);
        checks++;
        if (seen !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL drop_flag0_add: got seen=%b rdy=%b expected 0/1", seen, in_ready);
        end
        run_op(5'd4, 32'd9, 32'd3, 1'b0, 8'd2, 40, seen, lat, d, rg, dz);
        checks++;
        if (seen !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL drop_flag0_div: got seen=%b rdy=%b busy=%b expected 0/1/0", seen, in_ready, busy);
        end
        run_op(5'd8, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b1, 8'd11, 5, seen, lat, d, rg, dz);
        checks++;
        if ({lat == 1, rg, d} !== {1'b1, 8'd11, 32'h0F00_0F00}) begin
            errors++; $display("FAIL after_drop_and: got lat=%0d reg=%0d data=%h expected 1/11/0f000f00", lat, rg, d);
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; ALU_op = '0; ALU_v1 = '0; ALU_v2 = '0;
        ALU_write_back_flag = 1'b0; ALU_write_back_code = '0; wb_ready = 1'b1;
        test_reset();
        test_add_throughput();
        test_muldiv();
        test_single();
        test_backpressure();
        test_reset_mid_op();
        test_drops();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
